// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider, signed or unsigned, one quotient bit per cycle.
// A zero divisor skips the iteration and returns all-ones / the raw dividend.

module add_sub (
    input  logic        sub_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] r_o,
    output logic        carry_o
);
    logic [31:0] b_eff;

    // For subtraction, carry_o=1 means no borrow, i.e. a_i >= b_i.
    assign b_eff = sub_i ? ~b_i : b_i;
    assign {carry_o, r_o} = {1'b0, a_i} + {1'b0, b_eff} + {32'b0, sub_i};
endmodule

module div_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        rem_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] q_reg, r_reg, d_reg, result_reg;
    logic [4:0]  count_reg;
    logic        neg_q_reg, neg_r_reg, rem_sel_reg;

    logic [31:0] trial_a, trial_r, dividend_abs, divisor_abs, q_fix, r_fix;
    logic        trial_carry, success;

    assign trial_a = {r_reg[30:0], q_reg[31]};

    add_sub u_add_sub (
        .sub_i   (1'b1),
        .a_i     (trial_a),
        .b_i     (d_reg),
        .r_o     (trial_r),
        .carry_o (trial_carry)
    );

    // A set R[31] means the shifted partial remainder has 33 significant bits and always exceeds D.
    assign success      = trial_carry | r_reg[31];
    assign dividend_abs = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
    assign divisor_abs  = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
    assign q_fix        = neg_q_reg ? -q_reg : q_reg;
    assign r_fix        = neg_r_reg ? -r_reg : r_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_i) state_next = (divisor_i == 32'd0) ? DONE : RUN;
            RUN:  if (count_reg == 5'd31) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            result_reg  <= '0;
            count_reg   <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            rem_sel_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        if (divisor_i == 32'd0) begin
                            result_reg <= rem_i ? dividend_i : 32'hFFFF_FFFF;
                        end else begin
                            q_reg       <= dividend_abs;
                            d_reg       <= divisor_abs;
                            r_reg       <= '0;
                            count_reg   <= '0;
                            neg_q_reg   <= signed_i & (dividend_i[31] ^ divisor_i[31]);
                            neg_r_reg   <= signed_i & dividend_i[31];
                            rem_sel_reg <= rem_i;
                        end
                    end
                end
                RUN: begin
                    r_reg     <= success ? trial_r : trial_a;
                    q_reg     <= {q_reg[30:0], success};
                    count_reg <= count_reg + 5'd1;
                end
                FIX: result_reg <= rem_sel_reg ? r_fix : q_fix;
                default: ;
            endcase
        end
    end

    assign busy_o   = (state_reg != IDLE);
    assign valid_o  = (state_reg == DONE);
    assign result_o = result_reg;
endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized checks of div_seq against a 64-bit arithmetic reference.

module tb_div_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_in;
    logic        rem_in;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    div_seq dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .signed_i   (signed_in),
        .rem_i      (rem_in),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .busy_o     (busy),
        .valid_o    (valid),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Truncating division in 64 bits, so the signed overflow case needs no special handling.
    function automatic logic [31:0] ref_div(input bit s, input bit r,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, rm;
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q  = sa / sb;
        rm = sa % sb;
        return r ? rm[31:0] : q[31:0];
    endfunction

    // One division: start for one cycle, scramble operands, then watch busy/valid timing.
    task automatic run_op(input string tag, input bit s, input bit r,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        bit busy_ok;
        @(posedge clk); #1;
        signed_in = s; rem_in = r; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        signed_in = ~s; rem_in = ~r;
        cyc = 1;
        busy_ok = 1'b1;
        while (valid !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " result"}, result, exp_res);
        @(posedge clk); #1;
        check({tag, " pulse_end"}, {30'd0, valid, busy}, 32'd0);
        check({tag, " hold"}, result, exp_res);
        $display("op %s s=%0d r=%0d a=%h b=%h result=%h latency=%0d", tag, s, r, a, b, result, cyc);
    endtask

    initial begin
        logic [31:0] a, b, ra, rb;
        bit s, r;
        int pulses, cyc;

        rst = 1'b1; start = 1'b0; signed_in = 1'b0; rem_in = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {30'd0, busy, valid}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        run_op("u100div7_q", 0, 0, 32'd100, 32'd7, 32'd14, 34);
        run_op("u100div7_r", 0, 1, 32'd100, 32'd7, 32'd2, 34);
        run_op("s_m7div2_q", 1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("s_m7div2_r", 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("dz_u_q", 0, 0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("dz_u_r", 0, 1, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        run_op("dz_s_q", 1, 0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("dz_s_r", 1, 1, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        run_op("s_ovf_q", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_op("s_ovf_r", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        run_op("u_r31_q", 0, 0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34);
        run_op("u_r31_r", 0, 1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = rb >> $urandom_range(16, 31);
                2: b = 32'hFFFF_FFFF;
                default: b = rb;
            endcase
            a = (i % 7 == 3) ? 32'h8000_0000 : ra;
            run_op($sformatf("rand%0d", i), s, r, a, b, ref_div(s, r, a, b), (b == 32'd0) ? 1 : 34);
        end

        // Abort a division at counter=10 (the 11th cycle after start) with reset.
        @(posedge clk); #1;
        signed_in = 1'b0; rem_in = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_outputs", {30'd0, busy, valid}, 32'd0);
        check("abort_result", result, 32'd0);
        $display("abort busy=%0d valid=%0d result=%h", busy, valid, result);

        // Release reset and request in the same cycle; hold start through most of the run.
        rst = 1'b0;
        signed_in = 1'b0; rem_in = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        pulses = 0;
        cyc = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (k == 0) check("accept_after_reset", {31'd0, busy}, 32'd1);
            if (k == 20) begin
                start = 1'b0;
                dividend = 32'd7; divisor = 32'd0;
            end
            if (valid === 1'b1) begin
                pulses++;
                cyc = k + 1;
                check("held_start_result", result, 32'd333);
            end
        end
        check("held_start_pulses", pulses, 32'd1);
        check("held_start_latency", cyc, 32'd34);
        $display("held start pulses=%0d latency=%0d result=%h", pulses, cyc, result);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
